// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC, imem address, one-bubble squash on taken branch/jump.
// Macro FETCH_PERF_CNT_EN builds the fetch/flush counters; otherwise both outputs are tied to 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        regs_equal,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic        redirect,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        take_br, take_j;
  logic [31:0] pc_plus4, br_target, j_target;

  assign pc_plus4  = pc_q + 32'd4;
  assign take_br   = valid_q & ((branch_eq & regs_equal) | (branch_ne & ~regs_equal));
  assign take_j    = valid_q & jump;
  assign redirect  = ~stall & (take_br | take_j);
  assign br_target = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_target  = {pc4_q[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stall) begin
      if (redirect) begin
        // Jump has priority over branch if the decoder ever asserts both.
        pc_d    = take_j ? j_target : br_target;
        instr_d = 32'h0000_0000;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (!stall) begin
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      else          fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed branch/jump/stall/wrap/reset cases, then random control.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst, stall, branch_eq, branch_ne, jump, regs_equal;
  logic [31:0] imem_rdata, imem_addr, if_id_instr, if_id_pc4, fetch_count, flush_count;
  logic        if_id_valid, redirect;
  logic [5:0]  opcode;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .jump(jump), .regs_equal(regs_equal), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode), .redirect(redirect), .fetch_count(fetch_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr, instr, pc4, fc, flc;
    logic        valid, red;
    logic [5:0]  opc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: architectural view of PC and IF/ID.
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_flc;
  logic        m_v;

  logic [31:0] ov_addr[4];
  logic [31:0] ov_word[4];
  bit          ov_en[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (ov_en[i] && ov_addr[i] == a) return ov_word[i];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic bit branch_taken();
    return m_v && ((branch_eq && regs_equal) || (branch_ne && !regs_equal));
  endfunction

  function automatic bit jump_taken();
    return m_v && jump;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_v;
    e.opc   = m_instr[31:26];
    e.red   = !rst && !stall && (branch_taken() || jump_taken());
`ifdef FETCH_PERF_CNT_EN
    e.fc  = m_fc;
    e.flc = m_flc;
`else
    e.fc  = 32'd0;
    e.flc = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic model_step();
    int off;
    if (stall) return;
    if (jump_taken()) begin
      m_pc  = {m_pc4[31:28], m_instr[25:0], 2'b00};
      m_instr = 32'd0; m_pc4 = 32'd0; m_v = 1'b0; m_flc = m_flc + 32'd1;
    end else if (branch_taken()) begin
      off   = int'($signed(m_instr[15:0])) * 4;
      m_pc  = m_pc4 + 32'(off);
      m_instr = 32'd0; m_pc4 = 32'd0; m_v = 1'b0; m_flc = m_flc + 32'd1;
    end else begin
      m_instr = imem_rdata;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_v     = 1'b1;
      m_fc    = m_fc + 32'd1;
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = 32'd0; m_pc4 = 32'd0; m_v = 1'b0; m_fc = 32'd0; m_flc = 32'd0;
  endtask

  task automatic drive(input bit s, input bit be, input bit bn, input bit j, input bit re);
    @(posedge clk);
    #1;
    stall = s; branch_eq = be; branch_ne = bn; jump = j; regs_equal = re;
    imem_rdata = mem_word(m_pc);
    push_exp();
    model_step();
  endtask

  // Optionally asserts a jump first so reset lands while a redirect is being requested.
  task automatic do_reset(input bit mid_redirect);
    @(posedge clk);
    #1;
    if (mid_redirect) begin
      stall = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b1;
      #1;
    end
    rst = 1'b1;
    stall = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; regs_equal = 1'b0;
    model_reset();
    imem_rdata = mem_word(m_pc);
    push_exp();
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_rdata = mem_word(m_pc);
    push_exp();
    model_step();
  endtask

  task automatic set_ov(input int i, input logic [31:0] a, input logic [31:0] w);
    ov_en[i] = 1'b1; ov_addr[i] = a; ov_word[i] = w;
  endtask

  task automatic clear_ov();
    for (int i = 0; i < 4; i++) ov_en[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("imem_addr",   imem_addr,           e.addr);
      chk("if_id_instr", if_id_instr,         e.instr);
      chk("if_id_pc4",   if_id_pc4,           e.pc4);
      chk("if_id_valid", 32'(if_id_valid),    32'(e.valid));
      chk("opcode",      32'(opcode),         32'(e.opc));
      chk("redirect",    32'(redirect),       32'(e.red));
      chk("fetch_count", fetch_count,         e.fc);
      chk("flush_count", flush_count,         e.flc);
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0;
    regs_equal = 1'b0; imem_rdata = 32'd0;
    clear_ov();
    model_reset();

    // Sequential fetch from reset.
    do_reset(1'b0);
    repeat (4) drive(0, 0, 0, 0, 0);

    // j to 0x100, then beq imm=-2 held by a 2-cycle stall, then taken to 0x0FC.
    set_ov(0, 32'h0000_0040, {6'h02, 26'h000_0040});
    set_ov(1, 32'h0000_0100, {6'h04, 5'd1, 5'd2, 16'hFFFE});
    do_reset(1'b0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Same beq not taken.
    do_reset(1'b0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Backward branch wraps below zero to 0xFFFF_FFF8, then a jump keeps the top nibble.
    clear_ov();
    set_ov(0, 32'h0000_0040, {6'h04, 5'd0, 5'd0, 16'hFFED});
    set_ov(1, 32'hFFFF_FFF8, {6'h02, 26'h000_0400});
    do_reset(1'b0);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // PC wrap from 0xFFFF_FFFC with no redirect.
    do_reset(1'b0);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // bne taken and reset pulsed while a redirect is requested.
    clear_ov();
    do_reset(1'b0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    do_reset(1'b1);
    drive(0, 0, 0, 0, 0);

    // Random control traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0)
        do_reset(1'($urandom_range(1)));
      else
        drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
              $urandom_range(5) == 0, 1'($urandom_range(1)));
    end

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. Holds the PC, drives the instruction-memory address, and latches the fetched word and PC+4 into IF/ID, whose opcode field feeds the main decoder. It consumes the decoder's `branch_eq`, `branch_ne` and `jump` outputs, plus the ID-stage register comparison, to redirect the PC and squash the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard-unit hold request; freezes the PC and IF/ID.
- `branch_eq`  in  1  decoder output for the instruction in IF/ID.
- `branch_ne`  in  1  decoder output for the instruction in IF/ID.
- `jump`  in  1  decoder output for the instruction in IF/ID.
- `regs_equal`  in  1  ID-stage comparator: rs value == rt value.
- `imem_rdata`  in  32  instruction word at `imem_addr`; combinational read, valid in the same cycle.
- `imem_addr`  out  32  current PC.
- `if_id_instr`  out  32  latched instruction.
- `if_id_pc4`  out  32  latched PC+4.
- `if_id_valid`  out  1  IF/ID holds a real instruction, not a bubble.
- `opcode`  out  6  `if_id_instr[31:26]`, to the decoder.
- `redirect`  out  1  combinational: a taken branch or jump is accepted this cycle.
- `fetch_count`  out  32  count of valid instructions latched into IF/ID (see Configuration).
- `flush_count`  out  32  count of redirects (see Configuration).

## Operation
- `take_br` = `if_id_valid` & ((`branch_eq` & `regs_equal`) | (`branch_ne` & ~`regs_equal`)).
- `take_j` = `if_id_valid` & `jump`.
- `redirect` = ~`stall` & (`take_br` | `take_j`).
- Branch target = `if_id_pc4` + {{14{imm[15]}}, imm, 2'b00}, with imm = `if_id_instr[15:0]`. The sum is 32-bit modulo.
- Jump target = {`if_id_pc4[31:28]`, `if_id_instr[25:0]`, 2'b00}.
- If `take_j` and `take_br` are both true, the jump wins. The decoder never asserts both, but the priority is fixed anyway.
- Per-cycle update, highest priority first:
  1. `stall`: PC and all IF/ID fields hold. A pending branch or jump is not taken, because its operands are not yet valid.
  2. `redirect`:
     - PC <= target.
     - IF/ID <= bubble: `if_id_instr` = 32'h0000_0000 (sll $0, which is harmless), `if_id_pc4` = 0, `if_id_valid` = 0.
  3. Otherwise:
     - PC <= PC + 4.
     - IF/ID <= {`imem_rdata`, PC + 4, 1}.
- PC + 4 wraps: 32'hFFFF_FFFC becomes 32'h0000_0000.
- Bubbles never trigger a redirect, because of the `if_id_valid` qualification.
- The PC's two low bits are never set by any path: targets are word-aligned by construction.

## Timing
- Reset values, applied asynchronously:
  - PC = `RESET_PC`.
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0.
  - Both counters = 0.
  - `opcode` = 0.
- First rising edge after `rst` deasserts: the word at `RESET_PC` is latched, `if_id_valid` = 1, and PC = `RESET_PC` + 4.
- Fetch-to-decode latency: 1 cycle.
- Redirect penalty: exactly 1 bubble. The target instruction appears in IF/ID two edges after the branch/jump entered IF/ID, assuming no stall.
- A stall held for N cycles freezes all outputs for N edges. A redirect is evaluated on the first non-stalled cycle.
- `rst` asserted mid-operation returns all state to reset values immediately. Nothing pending survives.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined:
  - `fetch_count` increments on every edge that latches `if_id_valid` = 1.
  - `flush_count` increments on every edge where `redirect` = 1.
  - Both are 32 bits, wrap at 2^32, and are held during stall.
- Undefined: no counter flops are built, and both outputs are constant 0.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040, imem returning addr ^ 32'hA5A5_A5A5, 4 cycles -> `imem_addr` = 0x40, 0x44, 0x48, 0x4C; `if_id_pc4` trails by one cycle; `fetch_count` = 4.
- beq in IF/ID at PC 0x100 with imm = 16'hFFFE, `regs_equal` = 1 -> next PC = 0x0FC; one bubble (`if_id_valid` = 0, instr = 0); `flush_count` = 1. Same with `regs_equal` = 0 -> no redirect, PC = 0x108.
- j with `instr[25:0]` = 26'h0000_400, `if_id_pc4` = 32'h1000_0010 -> PC = 32'h1000_1000.
- beq taken while `stall` = 1 for 2 cycles -> PC and IF/ID unchanged for 2 edges; redirect occurs on the third edge.
- PC = 32'hFFFF_FFFC, no redirect -> next PC = 0, `if_id_pc4` = 0, `if_id_valid` = 1.
- `rst` pulsed mid-redirect -> all outputs return to reset values asynchronously; counters = 0.
